config_reg_ctrl: RTL

Two-port arbitrating access controller in front of `config_reg`, the 8 × 16-bit configuration register file. Two requesters issue read, write or masked-write (read-modify-write) transactions over a valid/ready handshake. The controller grants them round-robin and sequences the `config_reg` write/address/data_in pins, returning read data or the post-write value. A masked write is atomic: no other requester is granted between its read and its write phases.

---
 rtl/config_reg_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/config_reg_ctrl.sv
// Two-requester round-robin front end for the 8x16 config_reg file.
// Sequences read, write and atomic masked-write (read-modify-write) over config_reg pins.
module config_reg_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [DATA_W-1:0] req0_wmask,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_rerr,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [DATA_W-1:0] req1_wmask,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_rerr,
   output logic              cfg_write,
   output logic [ADDR_W-1:0] cfg_address,
   output logic [DATA_W-1:0] cfg_data_in,
   input  logic [DATA_W-1:0] cfg_data_out,
   output logic              busy
);

   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_MWR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, MODIFY, RESP} state_t;

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] wmask;
   } req_t;

   state_t      state, state_nx;
   req_t        req0, req1, req_q;
   logic        last_gnt, owner, phase;
   logic        gnt_any, gnt_sel, resp_ok;
   logic [DATA_W-1:0] rdata_q, merged;

   assign req0 = '{op: req0_op, addr: req0_addr, wdata: req0_wdata, wmask: req0_wmask};
   assign req1 = '{op: req1_op, addr: req1_addr, wdata: req1_wdata, wmask: req1_wmask};

   // Contention goes to whoever was not granted last; a lone requester always wins.
   assign gnt_any = (state == IDLE) && !reset && (req0_valid || req1_valid);
   assign gnt_sel = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;

   assign merged      = (rdata_q & ~req_q.wmask) | (req_q.wdata & req_q.wmask);
   assign cfg_address = req_q.addr;
   assign busy        = (state != IDLE);
   assign resp_ok     = (state == RESP) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         owner    <= 1'b0;
         phase    <= 1'b0;
         req_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state <= state_nx;
         if (gnt_any) begin
            last_gnt <= gnt_sel;
            owner    <= gnt_sel;
            phase    <= 1'b0;
            req_q    <= gnt_sel ? req1 : req0;
         end
         if (state == CAPTURE) begin
            rdata_q <= cfg_data_out;
            if (req_q.op == OP_MWR && !phase) phase <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      cfg_write   = 1'b0;
      cfg_data_in = '0;
      unique case (state)
         IDLE:    if (gnt_any) state_nx = ACCESS;
         ACCESS: begin
            state_nx = CAPTURE;
            if (req_q.op == OP_WR) begin
               cfg_write   = !reset;
               cfg_data_in = req_q.wdata;
            end
         end
         CAPTURE: state_nx = (req_q.op == OP_MWR && !phase) ? MODIFY : RESP;
         MODIFY: begin
            state_nx    = CAPTURE;
            cfg_write   = !reset;
            cfg_data_in = merged;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign req0_ready  = gnt_any && !gnt_sel;
   assign req1_ready  = gnt_any &&  gnt_sel;
   assign req0_rvalid = resp_ok && !owner;
   assign req1_rvalid = resp_ok &&  owner;
   assign req0_rdata  = req0_rvalid ? rdata_q : '0;
   assign req1_rdata  = req1_rvalid ? rdata_q : '0;
   assign req0_rerr   = req0_rvalid && (req_q.op == OP_RSV);
   assign req1_rerr   = req1_rvalid && (req_q.op == OP_RSV);

endmodule
